// File: rtl/pulse_seq_pkg.sv
// Shared types and default sizing for the pulse sequencer.
package pulse_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_e;

  localparam int unsigned DEF_CNT_W    = 14;
  localparam int unsigned DEF_NUM_W    = 5;
  localparam int unsigned DEF_PRESCALE = 100;

endpackage

// File: rtl/pulse_seq_prescaler.sv
// Mod-PRESCALE base-tick counter with enable and synchronous clear.
module pulse_seq_prescaler
  import pulse_seq_pkg::*;
#(
  parameter int unsigned PRESCALE = DEF_PRESCALE
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + PW'(1);
    end
  end

  always_comb begin
    tick = en && (cnt_q == LAST);
  end

endmodule

// File: rtl/pulse_sequencer.sv
// Burst pulse generator: HIGH/LOW phase FSM driven by a mod-PRESCALE base tick.
// Optional macro PULSE_SEQ_REPEAT_EN adds a CONTINUOUS input for endless bursts.
module pulse_sequencer
  import pulse_seq_pkg::*;
#(
  parameter int unsigned PRESCALE = DEF_PRESCALE,
  parameter int unsigned CNT_W    = DEF_CNT_W,
  parameter int unsigned NUM_W    = DEF_NUM_W
) (
  input  logic             CLKIN,
  input  logic             RESETN,
  input  logic             START,
  input  logic             ABORT,
  input  logic [CNT_W-1:0] HIGH_TICKS,
  input  logic [CNT_W-1:0] LOW_TICKS,
  input  logic [NUM_W-1:0] NUM_PULSES,
`ifdef PULSE_SEQ_REPEAT_EN
  input  logic             CONTINUOUS,
`endif
  output logic             PULSE_OUT,
  output logic             TICK,
  output logic             BUSY,
  output logic             DONE,
  output logic [NUM_W-1:0] PULSES_LEFT
);

  state_e             state_q, state_d;
  logic               pulse_q, pulse_d;
  logic               done_q, done_d;
  logic [NUM_W-1:0]   left_q, left_d;
  logic [CNT_W-1:0]   tcnt_q, tcnt_d;
  logic [CNT_W-1:0]   high_q, high_d;
  logic [CNT_W-1:0]   low_q, low_d;
  logic               cont_q;
  logic               start_cont;
  logic               busy;
  logic               tick;
  logic [NUM_W-1:0]   left_dec;

`ifdef PULSE_SEQ_REPEAT_EN
  logic cont_d;
  assign start_cont = CONTINUOUS;
`else
  assign cont_q     = 1'b0;
  assign start_cont = 1'b0;
`endif

  assign busy = (state_q != IDLE);

  // Prescaler is forced to 0 whenever the sequencer is idle or aborting.
  pulse_seq_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk   (CLKIN),
    .rst_n (RESETN),
    .en    (busy),
    .clr   (ABORT || !busy),
    .tick  (tick)
  );

  always_ff @(posedge CLKIN or negedge RESETN) begin
    if (!RESETN) begin
      state_q <= IDLE;
      pulse_q <= 1'b0;
      done_q  <= 1'b0;
      left_q  <= '0;
      tcnt_q  <= '0;
      high_q  <= '0;
      low_q   <= '0;
`ifdef PULSE_SEQ_REPEAT_EN
      cont_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pulse_q <= pulse_d;
      done_q  <= done_d;
      left_q  <= left_d;
      tcnt_q  <= tcnt_d;
      high_q  <= high_d;
      low_q   <= low_d;
`ifdef PULSE_SEQ_REPEAT_EN
      cont_q  <= cont_d;
`endif
    end
  end

  // Continuous bursts pin PULSES_LEFT at all-ones, so the "last pulse" test never fires.
  assign left_dec = cont_q ? left_q : left_q - NUM_W'(1);

  always_comb begin
    state_d = state_q;
    pulse_d = pulse_q;
    done_d  = 1'b0;
    left_d  = left_q;
    tcnt_d  = tcnt_q;
    high_d  = high_q;
    low_d   = low_q;
`ifdef PULSE_SEQ_REPEAT_EN
    cont_d  = cont_q;
`endif
    if (ABORT) begin
      state_d = IDLE;
      pulse_d = 1'b0;
      left_d  = '0;
      tcnt_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (START) begin
            if ((HIGH_TICKS != '0) && (start_cont || (NUM_PULSES != '0))) begin
              state_d = HIGH;
              pulse_d = 1'b1;
              tcnt_d  = '0;
              high_d  = HIGH_TICKS;
              low_d   = LOW_TICKS;
              left_d  = start_cont ? '1 : NUM_PULSES - NUM_W'(1);
`ifdef PULSE_SEQ_REPEAT_EN
              cont_d  = CONTINUOUS;
`endif
            end else begin
              done_d = 1'b1;
            end
          end
        end
        HIGH: begin
          if (tick) begin
            if (tcnt_q == high_q - CNT_W'(1)) begin
              tcnt_d = '0;
              if ((left_q == '0) && !cont_q) begin
                state_d = IDLE;
                pulse_d = 1'b0;
                done_d  = 1'b1;
              end else if (low_q != '0) begin
                state_d = LOW;
                pulse_d = 1'b0;
              end else begin
                left_d = left_dec;
              end
            end else begin
              tcnt_d = tcnt_q + CNT_W'(1);
            end
          end
        end
        LOW: begin
          if (tick) begin
            if (tcnt_q == low_q - CNT_W'(1)) begin
              state_d = HIGH;
              pulse_d = 1'b1;
              left_d  = left_dec;
              tcnt_d  = '0;
            end else begin
              tcnt_d = tcnt_q + CNT_W'(1);
            end
          end
        end
        default: begin
          state_d = IDLE;
          pulse_d = 1'b0;
          left_d  = '0;
          tcnt_d  = '0;
        end
      endcase
    end
  end

  always_comb begin
    PULSE_OUT   = pulse_q;
    DONE        = done_q;
    BUSY        = busy;
    TICK        = tick;
    PULSES_LEFT = left_q;
  end

endmodule

// File: tb/tb_pulse_sequencer.sv
// Directed bench for pulse_sequencer with PRESCALE=4; define PULSE_SEQ_REPEAT_EN for the continuous test.
module tb_pulse_sequencer;

  localparam int unsigned P  = 4;
  localparam int unsigned CW = 14;
  localparam int unsigned NW = 5;

  logic          CLKIN      = 1'b0;
  logic          RESETN     = 1'b0;
  logic          START      = 1'b0;
  logic          ABORT      = 1'b0;
  logic [CW-1:0] HIGH_TICKS = '0;
  logic [CW-1:0] LOW_TICKS  = '0;
  logic [NW-1:0] NUM_PULSES = '0;
`ifdef PULSE_SEQ_REPEAT_EN
  logic          CONTINUOUS = 1'b0;
`endif
  logic          PULSE_OUT;
  logic          TICK;
  logic          BUSY;
  logic          DONE;
  logic [NW-1:0] PULSES_LEFT;

  int checks = 0;
  int errors = 0;

  pulse_sequencer #(
    .PRESCALE (P),
    .CNT_W    (CW),
    .NUM_W    (NW)
  ) dut (
    .CLKIN       (CLKIN),
    .RESETN      (RESETN),
    .START       (START),
    .ABORT       (ABORT),
    .HIGH_TICKS  (HIGH_TICKS),
    .LOW_TICKS   (LOW_TICKS),
    .NUM_PULSES  (NUM_PULSES),
`ifdef PULSE_SEQ_REPEAT_EN
    .CONTINUOUS  (CONTINUOUS),
`endif
    .PULSE_OUT   (PULSE_OUT),
    .TICK        (TICK),
    .BUSY        (BUSY),
    .DONE        (DONE),
    .PULSES_LEFT (PULSES_LEFT)
  );

  always #5 CLKIN = ~CLKIN;

  typedef struct packed {
    logic       pulse;
    logic [4:0] left;
    logic [7:0] cycles;
  } seg_t;

  typedef struct packed {
    logic [13:0] h;
    logic [13:0] l;
    logic [4:0]  n;
    logic        hold;
    logic [2:0]  nseg;
    seg_t [4:0]  seg;
  } burst_t;

  function automatic seg_t mkseg(input logic p, input logic [4:0] lf, input logic [7:0] cy);
    seg_t s;
    s.pulse  = p;
    s.left   = lf;
    s.cycles = cy;
    return s;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge CLKIN);
    #1;
  endtask

  task automatic chk_idle(input string tag, input logic done_exp);
    chk({tag, ".pulse"}, 32'(PULSE_OUT), 32'd0);
    chk({tag, ".busy"}, 32'(BUSY), 32'd0);
    chk({tag, ".done"}, 32'(DONE), 32'(done_exp));
    chk({tag, ".left"}, 32'(PULSES_LEFT), 32'd0);
    chk({tag, ".tick"}, 32'(TICK), 32'd0);
  endtask

  task automatic play(input burst_t b);
    HIGH_TICKS = b.h;
    LOW_TICKS  = b.l;
    NUM_PULSES = b.n;
    START      = 1'b1;
    step();
    START = b.hold && (b.nseg != 0);
    if (b.hold) begin
      HIGH_TICKS = 14'd7;
      LOW_TICKS  = 14'd9;
      NUM_PULSES = 5'd11;
    end
    if (b.nseg == 0) begin
      chk_idle("reject", 1'b1);
      step();
      chk_idle("reject_after", 1'b0);
      return;
    end
    for (int s = 0; s < int'(b.nseg); s++) begin
      for (int c = 0; c < int'(b.seg[s].cycles); c++) begin
        chk("seg.pulse", 32'(PULSE_OUT), 32'(b.seg[s].pulse));
        chk("seg.busy", 32'(BUSY), 32'd1);
        chk("seg.left", 32'(PULSES_LEFT), 32'(b.seg[s].left));
        chk("seg.done", 32'(DONE), 32'd0);
        chk("seg.tick", 32'(TICK), 32'((c % P) == (P - 1)));
        if ((s == int'(b.nseg) - 1) && (c == int'(b.seg[s].cycles) - 1)) START = 1'b0;
        step();
      end
    end
    chk_idle("burst_end", 1'b1);
    step();
    chk_idle("burst_after", 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    burst_t vec [6];
    for (int i = 0; i < 6; i++) vec[i] = '0;

    vec[0].h = 14'd2; vec[0].l = 14'd3; vec[0].n = 5'd3; vec[0].nseg = 3'd5;
    vec[0].seg[0] = mkseg(1'b1, 5'd2, 8'd8);
    vec[0].seg[1] = mkseg(1'b0, 5'd2, 8'd12);
    vec[0].seg[2] = mkseg(1'b1, 5'd1, 8'd8);
    vec[0].seg[3] = mkseg(1'b0, 5'd1, 8'd12);
    vec[0].seg[4] = mkseg(1'b1, 5'd0, 8'd8);

    vec[1].h = 14'd5; vec[1].l = 14'd1; vec[1].n = 5'd0;
    vec[2].h = 14'd0; vec[2].l = 14'd1; vec[2].n = 5'd3;

    vec[3].h = 14'd1; vec[3].l = 14'd0; vec[3].n = 5'd4; vec[3].nseg = 3'd4;
    vec[3].seg[0] = mkseg(1'b1, 5'd3, 8'd4);
    vec[3].seg[1] = mkseg(1'b1, 5'd2, 8'd4);
    vec[3].seg[2] = mkseg(1'b1, 5'd1, 8'd4);
    vec[3].seg[3] = mkseg(1'b1, 5'd0, 8'd4);

    vec[4].h = 14'd1; vec[4].l = 14'd2; vec[4].n = 5'd2; vec[4].hold = 1'b1; vec[4].nseg = 3'd3;
    vec[4].seg[0] = mkseg(1'b1, 5'd1, 8'd4);
    vec[4].seg[1] = mkseg(1'b0, 5'd1, 8'd8);
    vec[4].seg[2] = mkseg(1'b1, 5'd0, 8'd4);

    vec[5].h = 14'd3; vec[5].l = 14'd1; vec[5].n = 5'd1; vec[5].nseg = 3'd1;
    vec[5].seg[0] = mkseg(1'b1, 5'd0, 8'd12);

    #12;
    chk_idle("reset", 1'b0);
    RESETN = 1'b1;
    step();
    chk_idle("post_reset", 1'b0);

    for (int i = 0; i < 6; i++) begin
      play(vec[i]);
      step();
    end

    // Abort five cycles into the second pulse, then restart one cycle later.
    HIGH_TICKS = 14'd2; LOW_TICKS = 14'd3; NUM_PULSES = 5'd3;
    START = 1'b1;
    step();
    START = 1'b0;
    repeat (20) step();
    chk("abort.p2_pulse", 32'(PULSE_OUT), 32'd1);
    chk("abort.p2_left", 32'(PULSES_LEFT), 32'd1);
    repeat (5) step();
    chk("abort.pre_pulse", 32'(PULSE_OUT), 32'd1);
    ABORT = 1'b1;
    step();
    ABORT = 1'b0;
    chk_idle("abort", 1'b0);
    step();
    chk_idle("abort_nodone", 1'b0);
    play(vec[5]);
    step();

    HIGH_TICKS = 14'd2; NUM_PULSES = 5'd3;
    START = 1'b1;
    ABORT = 1'b1;
    step();
    START = 1'b0;
    ABORT = 1'b0;
    chk_idle("start_abort", 1'b0);
    step();
    chk_idle("start_abort_after", 1'b0);

    // Asynchronous reset between edges while HIGH.
    HIGH_TICKS = 14'd2; LOW_TICKS = 14'd3; NUM_PULSES = 5'd3;
    START = 1'b1;
    step();
    START = 1'b0;
    repeat (2) step();
    chk("areset.pre_pulse", 32'(PULSE_OUT), 32'd1);
    #3;
    RESETN = 1'b0;
    #1;
    chk_idle("areset", 1'b0);
    #2;
    RESETN = 1'b1;
    step();
    chk_idle("areset_after", 1'b0);

`ifdef PULSE_SEQ_REPEAT_EN
    HIGH_TICKS = 14'd1; LOW_TICKS = 14'd1; NUM_PULSES = 5'd0;
    CONTINUOUS = 1'b1;
    START = 1'b1;
    step();
    START = 1'b0;
    CONTINUOUS = 1'b0;
    for (int per = 0; per < 42; per++) begin
      for (int c = 0; c < 8; c++) begin
        chk("cont.pulse", 32'(PULSE_OUT), 32'(c < 4));
        chk("cont.left", 32'(PULSES_LEFT), 32'h1f);
        chk("cont.done", 32'(DONE), 32'd0);
        chk("cont.busy", 32'(BUSY), 32'd1);
        step();
      end
    end
    ABORT = 1'b1;
    step();
    ABORT = 1'b0;
    chk_idle("cont_abort", 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
